// File: rtl/audio_sample_conditioner.sv
// Stereo conditioning between the DSP sample output and the I2S bridge.
// Applies volume with saturation, mute and a one-pole low-pass, then presents held registered samples.
`timescale 1ns/1ps
module audio_sample_conditioner #(
  parameter int DATA_WIDTH   = 16,
  parameter int VOL_WIDTH    = 8,
  parameter int FILTER_SHIFT = 1
) (
  input  logic                  clk_audio,
  input  logic                  reset_n,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] in_l,
  input  logic [DATA_WIDTH-1:0] in_r,
  input  logic [VOL_WIDTH-1:0]  volume,
  input  logic                  mute,
  output logic [DATA_WIDTH-1:0] audio_l,
  output logic [DATA_WIDTH-1:0] audio_r,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  clip,
  output logic                  drop
);

  localparam int PROD_WIDTH = DATA_WIDTH + VOL_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, SCALE_L, SCALE_R, FILT, OUT} state_t;
  state_t state, state_next;

  logic [DATA_WIDTH-1:0]        work_l, work_r, pend_l, pend_r;
  logic [VOL_WIDTH-1:0]         work_vol, pend_vol;
  logic                         work_mute, pend_mute, pend_full;
  logic signed [DATA_WIDTH-1:0] scaled_l, scaled_r, y_l, y_r;
  logic                         clip_l, clip_r;

  logic load_work_input, load_work_pend, load_pend, drop_now;

  logic [DATA_WIDTH-1:0]        mult_x;
  logic signed [PROD_WIDTH-1:0] mult_a, mult_b, product, shifted;
  logic                         sat_hi, sat_lo, sat_clip;
  logic [DATA_WIDTH-1:0]        sat_value;
  logic signed [DATA_WIDTH:0]   diff_l, diff_r;

  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // A strobe in the OUT cycle behaves like a pending sample and restarts the pipeline directly.
  always_comb begin
    state_next      = state;
    load_work_input = 1'b0;
    load_work_pend  = 1'b0;
    load_pend       = 1'b0;
    drop_now        = 1'b0;
    case (state)
      IDLE: begin
        if (sample_valid) begin
          load_work_input = 1'b1;
          state_next      = SCALE_L;
        end
      end
      SCALE_L: state_next = SCALE_R;
      SCALE_R: state_next = FILT;
      FILT:    state_next = OUT;
      OUT: begin
        if (pend_full) begin
          load_work_pend = 1'b1;
          load_pend      = sample_valid;
          state_next     = SCALE_L;
        end else if (sample_valid) begin
          load_work_input = 1'b1;
          state_next      = SCALE_L;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (sample_valid && (state inside {SCALE_L, SCALE_R, FILT})) begin
      load_pend = 1'b1;
      drop_now  = pend_full;
    end
  end

  assign busy = (state != IDLE);

  // One multiplier shared by both channels; volume is unsigned Q1.7.
  assign mult_x  = (state == SCALE_R) ? work_r : work_l;
  assign mult_a  = {{(VOL_WIDTH+1){mult_x[DATA_WIDTH-1]}}, mult_x};
  assign mult_b  = {{(DATA_WIDTH+1){1'b0}}, work_vol};
  assign product = mult_a * mult_b;
  assign shifted = product >>> (VOL_WIDTH - 1);
  assign sat_hi  = !shifted[PROD_WIDTH-1] &&  (|shifted[PROD_WIDTH-2:DATA_WIDTH-1]);
  assign sat_lo  =  shifted[PROD_WIDTH-1] && !(&shifted[PROD_WIDTH-2:DATA_WIDTH-1]);

  always_comb begin
    sat_value = shifted[DATA_WIDTH-1:0];
    sat_clip  = 1'b0;
    if (work_mute) begin
      sat_value = '0;
    end else if (sat_hi) begin
      sat_value = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      sat_clip  = 1'b1;
    end else if (sat_lo) begin
      sat_value = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      sat_clip  = 1'b1;
    end
  end

  assign diff_l = $signed({scaled_l[DATA_WIDTH-1], scaled_l}) - $signed({y_l[DATA_WIDTH-1], y_l});
  assign diff_r = $signed({scaled_r[DATA_WIDTH-1], scaled_r}) - $signed({y_r[DATA_WIDTH-1], y_r});

  // The filter result always lies between y and the target, so truncating back to DATA_WIDTH is exact.
  always_ff @(posedge clk_audio or negedge reset_n) begin
    if (!reset_n) begin
      work_l    <= '0;
      work_r    <= '0;
      work_vol  <= '0;
      work_mute <= 1'b0;
      pend_l    <= '0;
      pend_r    <= '0;
      pend_vol  <= '0;
      pend_mute <= 1'b0;
      pend_full <= 1'b0;
      scaled_l  <= '0;
      scaled_r  <= '0;
      clip_l    <= 1'b0;
      clip_r    <= 1'b0;
      y_l       <= '0;
      y_r       <= '0;
      audio_l   <= '0;
      audio_r   <= '0;
      out_valid <= 1'b0;
      clip      <= 1'b0;
      drop      <= 1'b0;
    end else begin
      out_valid <= (state == OUT);
      clip      <= (state == OUT) && (clip_l || clip_r);
      drop      <= drop_now;
      if (load_work_input) begin
        work_l    <= in_l;
        work_r    <= in_r;
        work_vol  <= volume;
        work_mute <= mute;
      end else if (load_work_pend) begin
        work_l    <= pend_l;
        work_r    <= pend_r;
        work_vol  <= pend_vol;
        work_mute <= pend_mute;
      end
      if (load_pend) begin
        pend_l    <= in_l;
        pend_r    <= in_r;
        pend_vol  <= volume;
        pend_mute <= mute;
        pend_full <= 1'b1;
      end else if (load_work_pend) begin
        pend_full <= 1'b0;
      end
      if (state == SCALE_L) begin
        scaled_l <= sat_value;
        clip_l   <= sat_clip;
      end
      if (state == SCALE_R) begin
        scaled_r <= sat_value;
        clip_r   <= sat_clip;
      end
      if (state == FILT) begin
        y_l <= DATA_WIDTH'($signed({y_l[DATA_WIDTH-1], y_l}) + (diff_l >>> FILTER_SHIFT));
        y_r <= DATA_WIDTH'($signed({y_r[DATA_WIDTH-1], y_r}) + (diff_r >>> FILTER_SHIFT));
      end
      if (state == OUT) begin
        audio_l <= y_l;
        audio_r <= y_r;
      end
    end
  end

endmodule

// File: tb/tb_audio_sample_conditioner.sv
// Bench for audio_sample_conditioner: one instance with the filter bypassed and one with FILTER_SHIFT=1,
// both driven by the same inputs and compared against an integer-arithmetic reference model.
`timescale 1ns/1ps
module tb_audio_sample_conditioner;

  logic        clk_audio = 1'b0;
  logic        reset_n;
  logic        sample_valid;
  logic [15:0] in_l, in_r;
  logic [7:0]  volume;
  logic        mute;

  logic [15:0] audio_l0, audio_r0, audio_l1, audio_r1;
  logic        out_valid0, busy0, clip0, drop0;
  logic        out_valid1, busy1, clip1, drop1;

  int compared   = 0;
  int mismatched = 0;
  int y0_l, y0_r, y1_l, y1_r;

  always #5 clk_audio = ~clk_audio;

  audio_sample_conditioner #(.DATA_WIDTH(16), .VOL_WIDTH(8), .FILTER_SHIFT(0)) dut0 (
    .clk_audio(clk_audio), .reset_n(reset_n), .sample_valid(sample_valid),
    .in_l(in_l), .in_r(in_r), .volume(volume), .mute(mute),
    .audio_l(audio_l0), .audio_r(audio_r0), .out_valid(out_valid0),
    .busy(busy0), .clip(clip0), .drop(drop0)
  );

  audio_sample_conditioner #(.DATA_WIDTH(16), .VOL_WIDTH(8), .FILTER_SHIFT(1)) dut1 (
    .clk_audio(clk_audio), .reset_n(reset_n), .sample_valid(sample_valid),
    .in_l(in_l), .in_r(in_r), .volume(volume), .mute(mute),
    .audio_l(audio_l1), .audio_r(audio_r1), .out_valid(out_valid1),
    .busy(busy1), .clip(clip1), .drop(drop1)
  );

  // Reference model: plain integer arithmetic with floor division.
  function automatic int floor_div(int a, int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic int model_scale(int x, int vol, bit m, output bit clipped);
    int s;
    clipped = 1'b0;
    if (m) return 0;
    s = floor_div(x * vol, 128);
    if (s > 32767) begin
      clipped = 1'b1;
      return 32767;
    end
    if (s < -32768) begin
      clipped = 1'b1;
      return -32768;
    end
    return s;
  endfunction

  function automatic int model_filter(int y, int s, int fs);
    return y + floor_div(s - y, 1 << fs);
  endfunction

  task automatic model_update(logic [15:0] l, logic [15:0] r, logic [7:0] vol, logic m,
                              output bit any_clip);
    int sl, sr;
    bit cl, cr;
    sl = model_scale(int'($signed(l)), int'(vol), m, cl);
    sr = model_scale(int'($signed(r)), int'(vol), m, cr);
    y0_l = model_filter(y0_l, sl, 0);
    y0_r = model_filter(y0_r, sr, 0);
    y1_l = model_filter(y1_l, sl, 1);
    y1_r = model_filter(y1_r, sr, 1);
    any_clip = cl | cr;
  endtask

  task automatic check16(string tag, logic [15:0] observed, logic [15:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check1(string tag, logic observed, logic expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_audio);
    #1;
  endtask

  task automatic apply_stimulus(logic [15:0] l, logic [15:0] r, logic [7:0] vol, logic m);
    sample_valid = 1'b1;
    in_l         = l;
    in_r         = r;
    volume       = vol;
    mute         = m;
  endtask

  task automatic check_output(string tag);
    check1({tag, "_ov0"}, out_valid0, 1'b1);
    check1({tag, "_ov1"}, out_valid1, 1'b1);
    check16({tag, "_l0"}, audio_l0, 16'(y0_l));
    check16({tag, "_r0"}, audio_r0, 16'(y0_r));
    check16({tag, "_l1"}, audio_l1, 16'(y1_l));
    check16({tag, "_r1"}, audio_r1, 16'(y1_r));
  endtask

  task automatic do_reset();
    sample_valid = 1'b0;
    reset_n      = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check16("rst_l0", audio_l0, 16'h0000);
    check16("rst_r0", audio_r0, 16'h0000);
    check16("rst_l1", audio_l1, 16'h0000);
    check16("rst_r1", audio_r1, 16'h0000);
    check1("rst_ov", out_valid0, 1'b0);
    check1("rst_busy", busy0, 1'b0);
    check1("rst_clip", clip0, 1'b0);
    check1("rst_drop", drop0, 1'b0);
    repeat (2) tick();
    reset_n = 1'b1;
    y0_l = 0; y0_r = 0; y1_l = 0; y1_r = 0;
  endtask

  // Single isolated sample: busy right after capture, result exactly four edges later, then idle.
  task automatic run_sample(string tag, logic [15:0] l, logic [15:0] r, logic [7:0] vol, logic m);
    bit exp_clip;
    apply_stimulus(l, r, vol, m);
    tick();
    sample_valid = 1'b0;
    model_update(l, r, vol, m, exp_clip);
    check1({tag, "_busy"}, busy0, 1'b1);
    repeat (3) tick();
    check1({tag, "_early0"}, out_valid0, 1'b0);
    check1({tag, "_early1"}, out_valid1, 1'b0);
    tick();
    check_output(tag);
    check1({tag, "_clip0"}, clip0, exp_clip);
    check1({tag, "_clip1"}, clip1, exp_clip);
    tick();
    check1({tag, "_ovend"}, out_valid0, 1'b0);
    check1({tag, "_clipend"}, clip0, 1'b0);
    check1({tag, "_idle"}, busy0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit dummy_clip;
    reset_n = 1'b1;
    sample_valid = 1'b0;
    in_l = '0; in_r = '0; volume = '0; mute = 1'b0;

    do_reset();
    run_sample("t1", 16'h1234, 16'hFF00, 8'h80, 1'b0);
    check16("t1_l_const", audio_l0, 16'h1234);
    check16("t1_r_const", audio_r0, 16'hFF00);

    run_sample("t2", 16'h7000, 16'h9000, 8'hFF, 1'b0);
    check16("t2_l_const", audio_l0, 16'h7FFF);
    check16("t2_r_const", audio_r0, 16'h8000);

    run_sample("t5a", 16'hFFFF, 16'h0000, 8'h40, 1'b0);
    check16("t5a_const", audio_l0, 16'hFFFF);
    run_sample("t5b", 16'h0001, 16'h0000, 8'h40, 1'b0);
    check16("t5b_const", audio_l0, 16'h0000);

    do_reset();
    run_sample("t3a", 16'h4000, 16'h4000, 8'h80, 1'b0);
    check16("t3a_const", audio_l1, 16'h2000);
    run_sample("t3b", 16'h4000, 16'h4000, 8'h80, 1'b0);
    check16("t3b_const", audio_l1, 16'h3000);
    run_sample("t3c", 16'h4000, 16'h4000, 8'h80, 1'b0);
    check16("t3c_const", audio_l1, 16'h3800);
    run_sample("t3m", 16'h4000, 16'h4000, 8'h80, 1'b1);
    check16("t3m_const", audio_l1, 16'h1C00);

    // Reset while the FILT step is in flight.
    apply_stimulus(16'h1000, 16'h1000, 8'h80, 1'b0);
    tick();
    sample_valid = 1'b0;
    repeat (2) tick();
    reset_n = 1'b0;
    #1;
    check16("t6_l1", audio_l1, 16'h0000);
    check16("t6_r1", audio_r1, 16'h0000);
    check1("t6_ov", out_valid1, 1'b0);
    check1("t6_busy", busy1, 1'b0);
    tick();
    reset_n = 1'b1;
    y0_l = 0; y0_r = 0; y1_l = 0; y1_r = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check1("t6_noval", out_valid1, 1'b0);
    end
    run_sample("t6post", 16'h4000, 16'h4000, 8'h80, 1'b0);
    check16("t6post_const", audio_l1, 16'h2000);

    // Three back-to-back strobes: the middle one is overwritten in the pending slot.
    apply_stimulus(16'h0100, 16'h0200, 8'h80, 1'b0);
    tick();
    apply_stimulus(16'h7777, 16'h7777, 8'h80, 1'b0);
    tick();
    apply_stimulus(16'h0300, 16'hFD00, 8'h80, 1'b0);
    tick();
    sample_valid = 1'b0;
    check1("t4_drop", drop0, 1'b1);
    tick();
    check1("t4_dropend", drop0, 1'b0);
    check1("t4_early", out_valid0, 1'b0);
    tick();
    model_update(16'h0100, 16'h0200, 8'h80, 1'b0, dummy_clip);
    check_output("t4_a");
    check1("t4_busy_a", busy0, 1'b1);
    repeat (3) tick();
    check1("t4_busy_mid", busy0, 1'b1);
    check1("t4_noout_b", out_valid0, 1'b0);
    tick();
    model_update(16'h0300, 16'hFD00, 8'h80, 1'b0, dummy_clip);
    check_output("t4_c");
    check1("t4_busy_end", busy0, 1'b0);
    check16("t4_c_const", audio_l0, 16'h0300);

    // A strobe landing in the OUT cycle restarts the pipeline without a drop.
    apply_stimulus(16'h0500, 16'h0600, 8'h80, 1'b0);
    tick();
    sample_valid = 1'b0;
    repeat (3) tick();
    apply_stimulus(16'hF000, 16'h0800, 8'hC0, 1'b0);
    tick();
    sample_valid = 1'b0;
    model_update(16'h0500, 16'h0600, 8'h80, 1'b0, dummy_clip);
    check_output("t4b_a");
    check1("t4b_busy", busy0, 1'b1);
    check1("t4b_nodrop", drop0, 1'b0);
    repeat (4) tick();
    model_update(16'hF000, 16'h0800, 8'hC0, 1'b0, dummy_clip);
    check_output("t4b_b");

    for (int i = 0; i < 30; i++) begin
      run_sample("rnd", 16'($urandom), 16'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
